// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding and limits for the reset sequencer
package reset_seq_pkg;
  localparam int MAX_STAGES = 8;
  typedef enum logic [2:0] {ASSERT, HOLD, RELEASE, WAIT, DONE, FAULT} seq_state_t;
endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: sequencer-side bundle of sw handshake, per-stage reset/ready and status
//   master (sequencer): in sw_rst_req, stage_ready; out sw_rst_ack, stage_rst_n, all_released, fault, fault_stage
//   slave  (board/sw) : the mirror image
interface reset_sequencer_if #(parameter int NUM_STAGES = 4);
  import reset_seq_pkg::*;
  logic sw_rst_req, sw_rst_ack, all_released, fault;
  logic [NUM_STAGES-1:0] stage_ready, stage_rst_n;
  logic [$clog2(MAX_STAGES)-1:0] fault_stage;
  modport master(input sw_rst_req, stage_ready, output sw_rst_ack, stage_rst_n, all_released, fault, fault_stage);
  modport slave(output sw_rst_req, stage_ready, input sw_rst_ack, stage_rst_n, all_released, fault, fault_stage);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser with async active-low clear
//   clk, rst_async_n : clock and async clear
//   d_i              : asynchronous input vector
//   q_o              : synchronised output, two edges behind d_i
module sync_2ff #(parameter int WIDTH = 1) (
  input  logic             clk,
  input  logic             rst_async_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] s1_q, s2_q;
  always_ff @(posedge clk or negedge rst_async_n)
    if (!rst_async_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  assign q_o = s2_q;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_STAGES reset domains in order, each gated by the previous stage's ready
//   clk, rst_async_n : clock and board reset (async assert, synchronised release)
//   bus (master)     : sw_rst_req/sw_rst_ack handshake, stage_ready in, stage_rst_n out,
//                      all_released, fault, fault_stage status
module reset_sequencer import reset_seq_pkg::*; #(
  parameter int NUM_STAGES    = 4,
  parameter int HOLD_CYCLES   = 16,
  parameter int READY_TIMEOUT = 1024
) (
  input logic              clk,
  input logic              rst_async_n,
  reset_sequencer_if.master bus
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = $clog2(READY_TIMEOUT + 1);
  localparam int IW = $clog2(MAX_STAGES);
  seq_state_t state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] to_q, to_d;
  logic [IW-1:0] idx_q, idx_d, fs_q, fs_d;
  logic [NUM_STAGES-1:0] rst_n_q, rst_n_d, ready_s;
  logic ack_q, ack_d, all_q, all_d, fault_q, fault_d;
  logic rst_s2, req_s, ready_cur, last, trig;
  sync_2ff #(.WIDTH(1)) u_rst_sync (.clk, .rst_async_n, .d_i(1'b1), .q_o(rst_s2));
  sync_2ff #(.WIDTH(1)) u_req_sync (.clk, .rst_async_n, .d_i(bus.sw_rst_req), .q_o(req_s));
  sync_2ff #(.WIDTH(NUM_STAGES)) u_rdy_sync (.clk, .rst_async_n, .d_i(bus.stage_ready), .q_o(ready_s));
  assign ready_cur = |(ready_s & (NUM_STAGES'(1) << idx_q));
  assign last = idx_q == IW'(NUM_STAGES - 1);
  // a new software sequence needs req seen low since the previous ack (4-phase)
  assign trig = (state_q == DONE || state_q == FAULT) && req_s && !ack_q;
  always_ff @(posedge clk or negedge rst_async_n)
    if (!rst_async_n) begin
      state_q <= ASSERT;
      hold_q  <= '0;
      to_q    <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      ack_q   <= 1'b0;
      all_q   <= 1'b0;
      fault_q <= 1'b0;
      fs_q    <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      ack_q   <= ack_d;
      all_q   <= all_d;
      fault_q <= fault_d;
      fs_q    <= fs_d;
    end
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    to_d    = to_q;
    idx_d   = idx_q;
    case (state_q)
      ASSERT: begin
        hold_d = '0;
        if (rst_s2) state_d = HOLD;
      end
      HOLD: begin
        hold_d = hold_q + HW'(1);
        if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          state_d = RELEASE;
          idx_d   = '0;
        end
      end
      RELEASE: begin
        to_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        to_d = to_q + TW'(1);
        // ready on the timeout cycle still counts as in time
        if (ready_cur) begin
          state_d = last ? DONE : RELEASE;
          idx_d   = last ? idx_q : idx_q + IW'(1);
        end else if (to_q == TW'(READY_TIMEOUT - 1)) state_d = FAULT;
      end
      DONE, FAULT: if (trig) state_d = ASSERT;
      default: state_d = ASSERT;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_comb begin
    rst_n_d = state_d == ASSERT ? '0 : state_q == RELEASE ? rst_n_q | (NUM_STAGES'(1) << idx_q) : rst_n_q;
    ack_d   = trig ? 1'b1 : (state_d == DONE || state_d == FAULT) ? ack_q & req_s : ack_q;
    all_d   = state_d == DONE;
    fault_d = state_d == FAULT;
    fs_d    = state_d == FAULT ? idx_q : '0;
  end
  assign bus.stage_rst_n  = rst_n_q;
  assign bus.sw_rst_ack   = ack_q;
  assign bus.all_released = all_q;
  assign bus.fault        = fault_q;
  assign bus.fault_stage  = fs_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench; a timing model predicts every output change and a monitor checks them
module tb_reset_sequencer;
  localparam int NS = 4;
  localparam int HC = 16;
  localparam int TO = 1024;
  typedef struct {int e; logic [9:0] v;} ev_t;
  logic clk = 1'b0;
  logic rst_async_n;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int end_e;
  int d[NS];
  bit mon_en = 1'b0;
  logic [9:0] exp_vec = '0;
  ev_t q[$];
  reset_sequencer_if #(.NUM_STAGES(NS)) bus();
  reset_sequencer #(.NUM_STAGES(NS), .HOLD_CYCLES(HC), .READY_TIMEOUT(TO)) dut (
    .clk(clk), .rst_async_n(rst_async_n), .bus(bus));
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  function automatic logic [9:0] cur_vec();
    return {bus.sw_rst_ack, bus.all_released, bus.fault, bus.fault ? bus.fault_stage : 3'b0, bus.stage_rst_n};
  endfunction
  function automatic logic [9:0] mk(bit a, bit al, bit f, int fs, logic [3:0] r);
    return {a, al, f, f ? 3'(fs) : 3'b0, r};
  endfunction
  function automatic void push(int e, logic [9:0] v);
    if (v !== exp_vec) begin
      q.push_back('{e, v});
      exp_vec = v;
    end
  endfunction
  function automatic void fin(int f, bit ack, int lo, bit al, bit ft, int fs, logic [3:0] rn);
    bit keep;
    keep = ack && f < lo;
    push(f, mk(keep, al, ft, fs, rn));
    end_e = f;
    if (keep) begin
      push(lo, mk(1'b0, al, ft, fs, rn));
      end_e = lo;
    end
  endfunction
  // stage i leaves reset at edge r; its ready (raised d[i] cycles later) is seen 3+d[i] edges on,
  // the next stage follows one edge after that; no ready within TO edges means fault at r+TO
  function automatic void plan(int r0, bit ack, int lo);
    int r;
    logic [3:0] rn;
    r = r0;
    rn = '0;
    for (int i = 0; i < NS; i++) begin
      rn[i] = 1'b1;
      push(r, mk(ack, 1'b0, 1'b0, 0, rn));
      if (d[i] > TO - 3) begin
        fin(r + TO, ack, lo, 1'b0, 1'b1, i, rn);
        return;
      end
      if (i == NS - 1) fin(r + 3 + d[i], ack, lo, 1'b1, 1'b0, 0, rn);
      r += 4 + d[i];
    end
  endfunction
  task automatic run_until(int last, int on, int off);
    while (cyc < last) begin
      @(negedge clk);
      if (cyc == on) bus.sw_rst_req = 1'b1;
      if (cyc == off) bus.sw_rst_req = 1'b0;
    end
  endtask
  task automatic drain(string n);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain_%s: got no change for %0d events, required next %b at cyc %0d", n, q.size(), q[0].v, q[0].e);
    end
  endtask
  task automatic sw_seq(string n, int hold);
    int a;
    @(negedge clk);
    a = cyc;
    bus.sw_rst_req = 1'b1;
    push(a + 3, mk(1'b1, 1'b0, 1'b0, 0, 4'b0));
    plan(a + HC + 5, 1'b1, a + hold + 3);
    run_until(end_e + 4, -1, a + hold);
    drain(n);
  endtask
  // stage emulator: ready follows its reset release by d[i] cycles, drops while in reset
  initial begin
    int cnt[NS];
    bus.stage_ready = '0;
    foreach (cnt[i]) cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NS; i++)
        if (bus.stage_rst_n[i] !== 1'b1) begin
          bus.stage_ready[i] = 1'b0;
          cnt[i] = 0;
        end else if (!bus.stage_ready[i]) begin
          if (cnt[i] == d[i]) bus.stage_ready[i] = 1'b1;
          else cnt[i]++;
        end
    end
  end
  initial begin
    logic [9:0] v, prev;
    ev_t x;
    prev = '0;
    forever begin
      @(negedge clk);
      #1;
      v = cur_vec();
      if (mon_en && v !== prev) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, v);
        end else begin
          x = q.pop_front();
          if (x.v !== v || x.e != cyc) begin
            fails++;
            $display("FAIL event: got %b at cyc %0d, required %b at cyc %0d", v, cyc, x.v, x.e);
          end
        end
      end
      prev = v;
    end
  end
  initial begin
    int e, a;
    d = '{0, 0, 0, 0};
    rst_async_n = 1'b1;
    bus.sw_rst_req = 1'b0;
    #1 rst_async_n = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (cur_vec() !== 10'b0) begin
      fails++;
      $display("FAIL reset_state: got %b required %b", cur_vec(), 10'b0);
    end
    mon_en = 1'b1;
    e = cyc;
    rst_async_n = 1'b1;
    plan(e + HC + 4, 1'b0, 0);
    run_until(end_e + 4, e + 5, e + 8);
    drain("powerup");
    sw_seq("sw50", 50);
    d = '{0, 100, 0, 0};
    @(negedge clk);
    a = cyc;
    bus.sw_rst_req = 1'b1;
    push(a + 3, mk(1'b1, 1'b0, 1'b0, 0, 4'b0));
    plan(a + HC + 5, 1'b1, a + 8);
    run_until(a + 35, -1, a + 5);
    q.delete();
    exp_vec = mk(1'b1, 1'b0, 1'b0, 0, 4'b0011);
    rst_async_n = 1'b0;
    push(cyc, 10'b0);
    @(negedge clk);
    rst_async_n = 1'b1;
    d[1] = 0;
    e = cyc;
    plan(e + HC + 4, 1'b0, 0);
    run_until(end_e + 4, -1, -1);
    drain("abort");
    d = '{0, 0, 2000, 0};
    sw_seq("fault2", 5);
    d = '{0, 1021, 0, 0};
    sw_seq("edge_ok", 200);
    d = '{0, 1022, 0, 0};
    sw_seq("edge_fault", 3);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NS; i++) d[i] = ($urandom_range(0, 9) == 0) ? 1030 : int'($urandom_range(0, 6));
      sw_seq("rand", int'($urandom_range(1, 80)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
